// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the execute-stage forwarding / load-use hazard unit.
// Forward-select codes, hazard FSM state encoding and default widths.
package fwd_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  localparam logic [1:0] FWD_SEL_RF = 2'b00;
  localparam logic [1:0] FWD_SEL_P1 = 2'b01;
  localparam logic [1:0] FWD_SEL_P2 = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Saturating 16-bit increment used by the optional statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Operand/producer bundle between the pipeline and fwd_hazard_unit.
// Statistics signals exist only when FWD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] src_num;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_SRC*DATA_W-1:0] src_rf_val;
  logic                      p1_valid;
  logic [REG_AW-1:0]         p1_num;
  logic [DATA_W-1:0]         p1_val;
  logic                      p1_m2r;
  logic                      p2_valid;
  logic [REG_AW-1:0]         p2_num;
  logic [DATA_W-1:0]         p2_val;
  logic                      flush;
  logic [NUM_SRC*DATA_W-1:0] src_val;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
`ifdef FWD_STATS_EN
  logic [15:0]               stat_fwd1;
  logic [15:0]               stat_fwd2;
  logic [15:0]               stat_stall;

  modport master (
    output src_num, src_used, src_rf_val, p1_valid, p1_num, p1_val, p1_m2r,
           p2_valid, p2_num, p2_val, flush,
    input  src_val, fwd_sel, stall, bubble, stat_fwd1, stat_fwd2, stat_stall
  );
  modport slave (
    input  src_num, src_used, src_rf_val, p1_valid, p1_num, p1_val, p1_m2r,
           p2_valid, p2_num, p2_val, flush,
    output src_val, fwd_sel, stall, bubble, stat_fwd1, stat_fwd2, stat_stall
  );
`else
  modport master (
    output src_num, src_used, src_rf_val, p1_valid, p1_num, p1_val, p1_m2r,
           p2_valid, p2_num, p2_val, flush,
    input  src_val, fwd_sel, stall, bubble
  );
  modport slave (
    input  src_num, src_used, src_rf_val, p1_valid, p1_num, p1_val, p1_m2r,
           p2_valid, p2_num, p2_val, flush,
    output src_val, fwd_sel, stall, bubble
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit_src_mux.sv
// One source operand: producer match, youngest-first priority mux and
// load-use hazard flag. Purely combinational.
module fwd_src_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              i_used,
  input  logic [REG_AW-1:0] i_num,
  input  logic [DATA_W-1:0] i_rf_val,
  input  logic              i_p1_valid,
  input  logic [REG_AW-1:0] i_p1_num,
  input  logic [DATA_W-1:0] i_p1_val,
  input  logic              i_p1_m2r,
  input  logic              i_p2_valid,
  input  logic [REG_AW-1:0] i_p2_num,
  input  logic [DATA_W-1:0] i_p2_val,
  output logic [DATA_W-1:0] o_val,
  output logic [1:0]        o_sel,
  output logic              o_haz
);
  logic w_m1;
  logic w_m2;

  assign w_m1  = i_used & i_p1_valid & (i_p1_num == i_num);
  assign w_m2  = i_used & i_p2_valid & (i_p2_num == i_num);
  assign o_haz = w_m1 & i_p1_m2r;

  // A pending load in stage 1 is skipped, so the stalled cycle still
  // resolves deterministically to stage 2 or the register file.
  always_comb begin
    o_val = i_rf_val;
    o_sel = FWD_SEL_RF;
    if (w_m1 && !i_p1_m2r) begin
      o_val = i_p1_val;
      o_sel = FWD_SEL_P1;
    end else if (w_m2) begin
      o_val = i_p2_val;
      o_sel = FWD_SEL_P2;
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Execute-stage operand forwarding with a load-use stall FSM.
// Define FWD_STATS_EN to add saturating forward/stall statistics counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_unit_if.slave bus
);
  localparam logic [2:0] CNT_LOAD = 3'(LOAD_LAT - 1);

  logic [NUM_SRC-1:0] w_haz_vec;
  logic [NUM_SRC-1:0] w_is_p1;
  logic [NUM_SRC-1:0] w_is_p2;
  logic [NUM_SRC*DATA_W-1:0] w_src_val;
  logic [NUM_SRC*2-1:0]      w_fwd_sel;
  logic w_haz;
  logic w_stall;
  logic [0:0] r_state;
  logic [2:0] r_cnt;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux (
        .i_used     (bus.src_used[gi]),
        .i_num      (bus.src_num[gi*REG_AW +: REG_AW]),
        .i_rf_val   (bus.src_rf_val[gi*DATA_W +: DATA_W]),
        .i_p1_valid (bus.p1_valid),
        .i_p1_num   (bus.p1_num),
        .i_p1_val   (bus.p1_val),
        .i_p1_m2r   (bus.p1_m2r),
        .i_p2_valid (bus.p2_valid),
        .i_p2_num   (bus.p2_num),
        .i_p2_val   (bus.p2_val),
        .o_val      (w_src_val[gi*DATA_W +: DATA_W]),
        .o_sel      (w_fwd_sel[gi*2 +: 2]),
        .o_haz      (w_haz_vec[gi])
      );
      assign w_is_p1[gi] = (w_fwd_sel[gi*2 +: 2] == FWD_SEL_P1);
      assign w_is_p2[gi] = (w_fwd_sel[gi*2 +: 2] == FWD_SEL_P2);
    end
  endgenerate

  assign w_haz   = |w_haz_vec;
  assign w_stall = !rst && !bus.flush && ((r_state == ST_WAIT) || w_haz);

  assign bus.src_val = w_src_val;
  assign bus.fwd_sel = w_fwd_sel;
  assign bus.stall   = w_stall;
  assign bus.bubble  = w_stall;

  // The IDLE cycle that detects the hazard is the first stall cycle; r_cnt
  // then holds the WAIT cycles still to go, including the current one.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_haz && (LOAD_LAT > 1)) begin
        r_state <= ST_WAIT;
        r_cnt   <= CNT_LOAD;
      end
    end else if (r_cnt <= 3'd1) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] r_stat_fwd1;
  logic [15:0] r_stat_fwd2;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fwd1  <= 16'd0;
      r_stat_fwd2  <= 16'd0;
      r_stat_stall <= 16'd0;
    end else begin
      if (|w_is_p1) r_stat_fwd1  <= sat_inc(r_stat_fwd1);
      if (|w_is_p2) r_stat_fwd2  <= sat_inc(r_stat_fwd2);
      if (w_stall)  r_stat_stall <= sat_inc(r_stat_stall);
    end
  end

  assign bus.stat_fwd1  = r_stat_fwd1;
  assign bus.stat_fwd2  = r_stat_fwd2;
  assign bus.stat_stall = r_stat_stall;
`endif
endmodule
